// File: rtl/smart_toilet_flow_seq_if.sv
// Host-side bundle for the smart_toilet inlet pump/valve sequencer:
// assay requests and supply status in, pump enables and status out.
interface smart_toilet_flow_seq_if;
    logic       start;
    logic       abort;
    logic       pressure_ok;
    logic [2:0] pump_en;
    logic       busy;
    logic       out_valid;
    logic       done;
    logic       aborted;
    logic [2:0] state;

    modport master (
        output start, abort, pressure_ok,
        input  pump_en, busy, out_valid, done, aborted, state
    );

    modport slave (
        input  start, abort, pressure_ok,
        output pump_en, busy, out_valid, done, aborted, state
    );
endinterface

// File: rtl/smart_toilet_flow_seq.sv
// Staggered inlet sequencer: soln3 leads, soln2 joins, soln1 joins, then a
// soln1-only carrier flush, so both fluid fronts reach their mixers together.
module smart_toilet_flow_seq #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned T3_CYCLES    = 600,
    parameter int unsigned T2_CYCLES    = 400,
    parameter int unsigned RUN_CYCLES   = 1000,
    parameter int unsigned OUT_LAT      = 120,
    parameter int unsigned FLUSH_CYCLES = 300
) (
    input  logic                   clk,
    input  logic                   rst_n,
    smart_toilet_flow_seq_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME3 = 3'd1,
        ST_PRIME2 = 3'd2,
        ST_RUN    = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam longint          CNT_SPAN   = longint'(64'd1) << CNT_W;
    localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] LD_T3     = (T3_CYCLES    != 32'd0) ? CNT_W'(T3_CYCLES - 32'd1)    : ZERO_C;
    localparam logic [CNT_W-1:0] LD_T2     = (T2_CYCLES    != 32'd0) ? CNT_W'(T2_CYCLES - 32'd1)    : ZERO_C;
    localparam logic [CNT_W-1:0] LD_RUN    = (RUN_CYCLES   != 32'd0) ? CNT_W'(RUN_CYCLES - 32'd1)   : ZERO_C;
    localparam logic [CNT_W-1:0] LD_FLUSH  = (FLUSH_CYCLES != 32'd0) ? CNT_W'(FLUSH_CYCLES - 32'd1) : ZERO_C;
    // RUN counts down from RUN_CYCLES-1, so "counted >= OUT_LAT" means counter <= VALID_MAX.
    localparam bit               VALID_EVER = (OUT_LAT < RUN_CYCLES);
    localparam logic [CNT_W-1:0] VALID_MAX  = VALID_EVER ? CNT_W'(RUN_CYCLES - 32'd1 - OUT_LAT) : ZERO_C;

    generate
        if ((RUN_CYCLES == 32'd0) || (longint'(T3_CYCLES) > CNT_SPAN) || (longint'(T2_CYCLES) > CNT_SPAN) ||
            (longint'(RUN_CYCLES) > CNT_SPAN) || (longint'(FLUSH_CYCLES) > CNT_SPAN)) begin : g_bad_len
            $error("smart_toilet_flow_seq: phase length out of range for CNT_W");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             aborted_q, aborted_d;
    logic             load_s, dec_s;
    logic [2:0]       pump_en_q, pump_en_d;
    logic             busy_q, busy_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;

    function automatic state_e next_phase(input state_e s);
        state_e r;
        case (s)
            ST_PRIME3: r = ST_PRIME2;
            ST_PRIME2: r = ST_RUN;
            ST_RUN:    r = ST_FLUSH;
            ST_FLUSH:  r = ST_DONE;
            default:   r = ST_IDLE;
        endcase
        return r;
    endfunction

    // Resolve a requested phase to the first non-empty one at or after it.
    function automatic state_e enter_phase(input state_e s);
        state_e r;
        case (s)
            ST_PRIME3: r = (T3_CYCLES != 32'd0) ? ST_PRIME3 : ((T2_CYCLES != 32'd0) ? ST_PRIME2 : ST_RUN);
            ST_PRIME2: r = (T2_CYCLES != 32'd0) ? ST_PRIME2 : ST_RUN;
            ST_FLUSH:  r = (FLUSH_CYCLES != 32'd0) ? ST_FLUSH : ST_DONE;
            default:   r = s;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] phase_load(input state_e s);
        logic [CNT_W-1:0] r;
        case (s)
            ST_PRIME3: r = LD_T3;
            ST_PRIME2: r = LD_T2;
            ST_RUN:    r = LD_RUN;
            ST_FLUSH:  r = LD_FLUSH;
            default:   r = ZERO_C;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] pump_decode(input state_e s);
        logic [2:0] r;
        case (s)
            ST_PRIME3: r = 3'b100;
            ST_PRIME2: r = 3'b110;
            ST_RUN:    r = 3'b111;
            ST_FLUSH:  r = 3'b001;
            default:   r = 3'b000;
        endcase
        return r;
    endfunction

    // Next-state, phase counter and sticky abort flag.
    always_comb begin
        state_d   = state_q;
        aborted_d = aborted_q;
        load_s    = 1'b0;
        dec_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = enter_phase(ST_PRIME3);
                    aborted_d = 1'b0;
                    load_s    = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_PRIME3, ST_PRIME2, ST_RUN: begin
                if (bus.abort) begin
                    state_d   = enter_phase(ST_FLUSH);
                    aborted_d = 1'b1;
                    load_s    = 1'b1;
                end else if (!bus.pressure_ok) begin
                    state_d   = state_q;
                end else if (cnt_q == ZERO_C) begin
                    state_d   = enter_phase(next_phase(state_q));
                    load_s    = 1'b1;
                end else begin
                    dec_s     = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (!bus.pressure_ok) begin
                    state_d   = ST_FLUSH;
                end else if (cnt_q == ZERO_C) begin
                    state_d   = ST_DONE;
                    load_s    = 1'b1;
                end else begin
                    dec_s     = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                load_s  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                load_s  = 1'b1;
            end
        endcase
        cnt_d = load_s ? phase_load(state_d) : (dec_s ? (cnt_q - CNT_W'(1)) : cnt_q);
    end

    // Output decode from the upcoming state so registered outputs line up with it.
    always_comb begin
        pump_en_d   = bus.pressure_ok ? pump_decode(state_d) : 3'b000;
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        out_valid_d = VALID_EVER && bus.pressure_ok && (state_d == ST_RUN) && (cnt_d <= VALID_MAX);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= ZERO_C;
            aborted_q   <= 1'b0;
            pump_en_q   <= 3'b000;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            aborted_q   <= aborted_d;
            pump_en_q   <= pump_en_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.pump_en   = pump_en_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_smart_toilet_flow_seq.sv
// Directed bench: dut_a uses T3=3 T2=2 RUN=5 OUT_LAT=2 FLUSH=4,
// dut_b the all-skip variant T3=0 T2=0 FLUSH=0.
module tb_smart_toilet_flow_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_done = 0;

    always #5 clk = ~clk;

    smart_toilet_flow_seq_if ia ();
    smart_toilet_flow_seq_if ib ();

    smart_toilet_flow_seq #(.CNT_W(16), .T3_CYCLES(3), .T2_CYCLES(2), .RUN_CYCLES(5),
                            .OUT_LAT(2), .FLUSH_CYCLES(4))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));

    smart_toilet_flow_seq #(.CNT_W(16), .T3_CYCLES(0), .T2_CYCLES(0), .RUN_CYCLES(5),
                            .OUT_LAT(2), .FLUSH_CYCLES(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] pump_of(input int st);
        case (st)
            1:       return 3'b100;
            2:       return 3'b110;
            3:       return 3'b111;
            4:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Nominal dut_a timeline after a start in cycle 0.
    function automatic int nom_state(input int c);
        if (c <= 3)  return 1;
        if (c <= 5)  return 2;
        if (c <= 10) return 3;
        if (c <= 14) return 4;
        if (c == 15) return 5;
        return 0;
    endfunction

    task automatic chk_all(input bit use_b, input string t, input int c, input logic [2:0] pump,
                           input logic busy, input logic valid, input logic done, input int st);
        logic [2:0] o_pump, o_st;
        logic       o_busy, o_valid, o_done;
        o_pump  = use_b ? ib.pump_en   : ia.pump_en;
        o_busy  = use_b ? ib.busy      : ia.busy;
        o_valid = use_b ? ib.out_valid : ia.out_valid;
        o_done  = use_b ? ib.done      : ia.done;
        o_st    = use_b ? ib.state     : ia.state;
        chk($sformatf("%s.c%0d.pump_en", t, c), o_pump, pump);
        chk($sformatf("%s.c%0d.busy", t, c), o_busy, busy);
        chk($sformatf("%s.c%0d.out_valid", t, c), o_valid, valid);
        chk($sformatf("%s.c%0d.done", t, c), o_done, done);
        chk($sformatf("%s.c%0d.state", t, c), o_st, st[2:0]);
    endtask

    initial begin
        int st;
        ia.start = 1'b0; ia.abort = 1'b0; ia.pressure_ok = 1'b1;
        ib.start = 1'b0; ib.abort = 1'b0; ib.pressure_ok = 1'b1;

        // Reset state
        nxt(); nxt(); nxt();
        chk_all(1'b0, "rst_a", 0, 3'b000, 1'b0, 1'b0, 1'b0, 0);
        chk("rst_a.aborted", ia.aborted, 1'b0);
        chk_all(1'b1, "rst_b", 0, 3'b000, 1'b0, 1'b0, 1'b0, 0);
        rst_n = 1'b1;
        nxt();

        // 1 Nominal
        ia.start = 1'b1;
        nxt();
        ia.start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            st = nom_state(c);
            chk_all(1'b0, "nom", c, pump_of(st), st != 0, (c >= 8) && (c <= 10), c == 15, st);
            nxt();
        end

        // 2 Pressure hold in RUN (pressure_ok low in cycles 7..10)
        ia.start = 1'b1;
        nxt();
        ia.start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c <= 3)       st = 1;
            else if (c <= 5)  st = 2;
            else if (c <= 14) st = 3;
            else if (c <= 18) st = 4;
            else if (c == 19) st = 5;
            else              st = 0;
            chk_all(1'b0, "hold", c, ((c >= 8) && (c <= 11)) ? 3'b000 : pump_of(st), st != 0,
                    (c >= 12) && (c <= 14), c == 19, st);
            ia.pressure_ok = ((c >= 7) && (c <= 10)) ? 1'b0 : 1'b1;
            nxt();
        end
        ia.pressure_ok = 1'b1;

        // 3 Abort in the second PRIME2 cycle
        ia.start = 1'b1;
        nxt();
        ia.start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (c <= 3)       st = 1;
            else if (c <= 5)  st = 2;
            else if (c <= 9)  st = 4;
            else if (c == 10) st = 5;
            else              st = 0;
            chk_all(1'b0, "abort", c, pump_of(st), st != 0, 1'b0, c == 10, st);
            chk($sformatf("abort.c%0d.aborted", c), ia.aborted, c >= 6);
            ia.abort = (c == 5);
            nxt();
        end
        ia.abort = 1'b0;

        // 4 Skipped phases on dut_b: straight to RUN, then DONE
        ib.start = 1'b1;
        nxt();
        ib.start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            st = (c <= 5) ? 3 : ((c == 6) ? 5 : 0);
            chk_all(1'b1, "skip", c, pump_of(st), st != 0, (c >= 3) && (c <= 5), c == 6, st);
            nxt();
        end
        ib.start = 1'b1;
        nxt();
        ib.start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            st = (c <= 2) ? 3 : ((c == 3) ? 5 : 0);
            chk_all(1'b1, "skip_abort", c, pump_of(st), st != 0, 1'b0, c == 3, st);
            chk($sformatf("skip_abort.c%0d.aborted", c), ib.aborted, c >= 3);
            ib.abort = (c == 2);
            nxt();
        end
        ib.abort = 1'b0;

        // 5 Ignored inputs: abort in IDLE, start held through busy, abort in FLUSH
        ia.abort = 1'b1;
        nxt();
        ia.abort = 1'b0;
        chk_all(1'b0, "idle_abort", 1, 3'b000, 1'b0, 1'b0, 1'b0, 0);
        chk("idle_abort.aborted", ia.aborted, 1'b1);
        ia.start = 1'b1;
        nxt();
        for (int c = 1; c <= 16; c++) begin
            st = nom_state(c);
            chk_all(1'b0, "held", c, pump_of(st), st != 0, (c >= 8) && (c <= 10), c == 15, st);
            chk($sformatf("held.c%0d.aborted", c), ia.aborted, 1'b0);
            ia.abort = (c == 12);
            nxt();
        end
        ia.abort = 1'b0;
        chk("held.c17.state", ia.state, 3'd1);
        ia.start = 1'b0;
        n_done = 0;
        for (int c = 17; c <= 31; c++) begin
            if (ia.done) n_done++;
            nxt();
        end
        chk("held.c32.state", ia.state, 3'd0);
        chk("held.done_pulses", n_done, 1);

        // 6 Async reset in RUN
        ia.start = 1'b1;
        nxt();
        ia.start = 1'b0;
        for (int c = 1; c <= 7; c++) nxt();
        chk("areset.pre.out_valid", ia.out_valid, 1'b1);
        chk("areset.pre.pump_en", ia.pump_en, 3'b111);
        rst_n = 1'b0;
        #1;
        chk("areset.pump_en", ia.pump_en, 3'b000);
        chk("areset.busy", ia.busy, 1'b0);
        chk("areset.out_valid", ia.out_valid, 1'b0);
        chk("areset.state", ia.state, 3'd0);
        nxt(); nxt();
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            nxt();
            chk_all(1'b0, "post_reset", c, 3'b000, 1'b0, 1'b0, 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
